// File: rtl/calc_key_sequencer.sv
// calc_key_sequencer: key-entry front end for the 3-bit sign-magnitude ALU.
// Builds A, operator and B from key codes, runs the ALU and latches its result.
//
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   key_valid/key_code       incoming key, accepted when key_ready is high
//   key_ready, key_err       accept strobe and illegal-key pulse
//   alu_a, alu_b, alu_sel    registered ALU operands and operation select
//   alu_answer/dz/z          ALU outputs, sampled ALU_LAT cycles after '='
//   busy                     high while waiting on the ALU
//   res_value/dz/z/valid     latched result and its 1-cycle update pulse
//   op_count                 completed operations, wraps, cleared by rst only
module calc_key_sequencer #(
    parameter int ALU_LAT = 1,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             key_valid,
    input  logic [3:0]       key_code,
    output logic             key_ready,
    output logic             key_err,
    output logic [2:0]       alu_a,
    output logic [2:0]       alu_b,
    output logic [1:0]       alu_sel,
    input  logic [4:0]       alu_answer,
    input  logic             alu_dz,
    input  logic             alu_z,
    output logic             busy,
    output logic [4:0]       res_value,
    output logic             res_dz,
    output logic             res_z,
    output logic             res_valid,
    output logic [CNT_W-1:0] op_count
);

    typedef enum logic [2:0] {
        A_SIGN, A_DIG, OP, B_SIGN, B_DIG, EQ, EXEC, SHOW
    } state_t;

    localparam int SW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
    localparam logic [SW-1:0] LAST = SW'(ALU_LAT - 1);

    state_t        state, state_n;
    logic [SW-1:0] cnt, cnt_n;
    logic          sign_a, sign_b, sa_n, sb_n;
    logic [2:0]    a_n, b_n;
    logic [1:0]    sel_n;
    logic          err_n, clr, cap;

    logic       acc, is_dig, is_minus, is_op, is_eq, is_clr;
    logic [1:0] d;

    assign key_ready = ~rst & (state != EXEC);
    assign busy      = ~rst & (state == EXEC);

    assign acc      = key_valid & key_ready;
    assign d        = key_code[1:0];
    assign is_dig   = (key_code[3:2] == 2'b00);
    assign is_minus = (key_code == 4'hB);
    assign is_op    = (key_code >= 4'hA) && (key_code <= 4'hD);
    assign is_eq    = (key_code == 4'hE);
    assign is_clr   = (key_code == 4'hF);

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        a_n     = alu_a;
        b_n     = alu_b;
        sel_n   = alu_sel;
        sa_n    = sign_a;
        sb_n    = sign_b;
        err_n   = 1'b0;
        clr     = 1'b0;
        cap     = 1'b0;
        if (state == EXEC) begin
            if (cnt == LAST) begin
                cap     = 1'b1;
                cnt_n   = '0;
                state_n = SHOW;
            end else begin
                cnt_n = cnt + 1'b1;
            end
        end else if (acc && is_clr) begin
            clr     = 1'b1;
            state_n = A_SIGN;
            a_n     = '0;
            b_n     = '0;
            sel_n   = '0;
            sa_n    = 1'b0;
            sb_n    = 1'b0;
        end else if (acc) begin
            err_n = 1'b1;
            case (state)
                A_SIGN, SHOW: begin
                    if (is_minus) begin
                        err_n   = 1'b0;
                        sa_n    = 1'b1;
                        state_n = A_DIG;
                    end else if (is_dig) begin
                        err_n   = 1'b0;
                        sa_n    = 1'b0;
                        a_n     = {1'b0, d};
                        state_n = OP;
                    end
                end
                A_DIG: begin
                    if (is_dig) begin
                        err_n   = 1'b0;
                        // a signed zero collapses to 000
                        a_n     = {sign_a & (|d), d};
                        state_n = OP;
                    end
                end
                OP: begin
                    if (is_op) begin
                        err_n   = 1'b0;
                        // A/B/C/D low bits are exactly add/sub/mul/mod
                        sel_n   = key_code[1:0];
                        state_n = B_SIGN;
                    end
                end
                B_SIGN: begin
                    if (is_minus) begin
                        err_n   = 1'b0;
                        sb_n    = 1'b1;
                        state_n = B_DIG;
                    end else if (is_dig) begin
                        err_n   = 1'b0;
                        sb_n    = 1'b0;
                        b_n     = {1'b0, d};
                        state_n = EQ;
                    end
                end
                B_DIG: begin
                    if (is_dig) begin
                        err_n   = 1'b0;
                        b_n     = {sign_b & (|d), d};
                        state_n = EQ;
                    end
                end
                EQ: begin
                    if (is_eq) begin
                        err_n   = 1'b0;
                        cnt_n   = '0;
                        state_n = EXEC;
                    end
                end
                default: begin
                    err_n = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= A_SIGN;
            cnt       <= '0;
            sign_a    <= 1'b0;
            sign_b    <= 1'b0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_sel   <= '0;
            key_err   <= 1'b0;
            res_value <= '0;
            res_dz    <= 1'b0;
            res_z     <= 1'b0;
            res_valid <= 1'b0;
            op_count  <= '0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            sign_a    <= sa_n;
            sign_b    <= sb_n;
            alu_a     <= a_n;
            alu_b     <= b_n;
            alu_sel   <= sel_n;
            key_err   <= err_n;
            res_valid <= cap;
            if (cap) begin
                res_value <= alu_answer;
                res_dz    <= alu_dz;
                res_z     <= alu_z;
                op_count  <= op_count + 1'b1;
            end else if (clr) begin
                res_value <= '0;
                res_dz    <= 1'b0;
                res_z     <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_calc_key_sequencer.sv
// Bench for calc_key_sequencer: directed vector table, reset-in-EXEC sequence,
// then random keys checked against an arithmetic model of the calculator.
module tb_calc_key_sequencer;

    localparam int LAT = 1;
    localparam int CW  = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          key_valid;
    logic [3:0]    key_code;
    logic          key_ready, key_err;
    logic [2:0]    alu_a, alu_b;
    logic [1:0]    alu_sel;
    logic [4:0]    alu_answer;
    logic          alu_dz, alu_z;
    logic          busy;
    logic [4:0]    res_value;
    logic          res_dz, res_z, res_valid;
    logic [CW-1:0] op_count;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    calc_key_sequencer #(.ALU_LAT(LAT), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .key_valid(key_valid), .key_code(key_code),
        .key_ready(key_ready), .key_err(key_err),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_answer(alu_answer), .alu_dz(alu_dz), .alu_z(alu_z),
        .busy(busy),
        .res_value(res_value), .res_dz(res_dz), .res_z(res_z),
        .res_valid(res_valid), .op_count(op_count)
    );

    // {dz, z, answer}; sel 00 mul, 01 mod, 10 add, 11 sub
    function automatic logic [6:0] alu_f(input int a, input int b,
                                         input logic [1:0] s);
        int   r;
        logic dz;
        r  = 0;
        dz = 1'b0;
        case (s)
            2'b00: r = a * b;
            2'b01: if (b == 0) dz = 1'b1; else r = a % b;
            2'b10: r = a + b;
            default: r = a - b;
        endcase
        return {dz, r == 0, r < 0, 4'(r < 0 ? -r : r)};
    endfunction

    function automatic int sm2i(input logic [2:0] v);
        return v[2] ? -int'(v[1:0]) : int'(v[1:0]);
    endfunction

    function automatic logic [2:0] enc(input int v);
        return {v < 0, 2'(v < 0 ? -v : v)};
    endfunction

    always_comb begin
        {alu_dz, alu_z, alu_answer} = alu_f(sm2i(alu_a), sm2i(alu_b), alu_sel);
    end

    // model: ph 0 expect A, 1 A after '-', 2 operator, 3 expect B,
    // 4 B after '-', 5 expect '=', 6 computing, 7 showing result
    int         ph, left, a_v, b_v, op, m_cnt;
    logic       m_err, m_rv, m_dz, m_z;
    logic [4:0] m_res;

    task automatic model_step(input logic kv, input logic [3:0] kc,
                              input logic r);
        int k;
        bit ok;
        k = int'(kc);
        if (r) begin
            ph = 0; left = 0; a_v = 0; b_v = 0; op = 0; m_cnt = 0;
            m_err = 0; m_rv = 0; m_res = '0; m_dz = 0; m_z = 0;
            return;
        end
        m_err = 0;
        m_rv  = 0;
        if (ph == 6) begin
            left--;
            if (left == 0) begin
                {m_dz, m_z, m_res} = alu_f(a_v, b_v, 2'(op));
                m_rv  = 1;
                m_cnt = (m_cnt + 1) % (1 << CW);
                ph    = 7;
            end
            return;
        end
        if (!kv) return;
        if (k == 15) begin
            ph = 0; a_v = 0; b_v = 0; op = 0;
            m_res = '0; m_dz = 0; m_z = 0;
            return;
        end
        ok = 0;
        case (ph)
            0, 7: if (k == 11) begin ph = 1; ok = 1; end
                  else if (k < 4) begin a_v = k; ph = 2; ok = 1; end
            1: if (k < 4) begin a_v = -k; ph = 2; ok = 1; end
            2: if (k >= 10 && k <= 13) begin
                   op = (k == 12) ? 0 : (k == 13) ? 1 : (k == 10) ? 2 : 3;
                   ph = 3; ok = 1;
               end
            3: if (k == 11) begin ph = 4; ok = 1; end
               else if (k < 4) begin b_v = k; ph = 5; ok = 1; end
            4: if (k < 4) begin b_v = -k; ph = 5; ok = 1; end
            5: if (k == 14) begin ph = 6; left = LAT; ok = 1; end
            default: ok = 0;
        endcase
        m_err = !ok;
    endtask

    function automatic logic [20:0] act_vec();
        return {key_ready, key_err, alu_a, alu_b, alu_sel, busy, res_valid,
                res_value, res_dz, res_z, op_count};
    endfunction

    function automatic logic [20:0] exp_vec(input logic r);
        return {(!r && ph != 6), m_err, enc(a_v), enc(b_v), 2'(op),
                (!r && ph == 6), m_rv, m_res, m_dz, m_z, 2'(m_cnt)};
    endfunction

    task automatic chk(input string nm, input logic [20:0] act,
                       input logic [20:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic cycle(input logic kv, input logic [3:0] kc, input logic r);
        @(negedge clk);
        key_valid = kv;
        key_code  = kc;
        rst       = r;
        @(posedge clk);
        model_step(kv, kc, r);
        #1;
        chk("model", act_vec(), exp_vec(r));
    endtask

    typedef struct {
        logic       kv;
        logic [3:0] kc;
        logic [20:0] e;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t v(input logic kv, input logic [3:0] kc,
                               input logic rdy, input logic err,
                               input logic [2:0] a, input logic [2:0] b,
                               input logic [1:0] sel, input logic bsy,
                               input logic rv, input logic [4:0] res,
                               input logic dz, input logic z,
                               input logic [1:0] cnt);
        vec_t t;
        t.kv = kv;
        t.kc = kc;
        t.e  = {rdy, err, a, b, sel, bsy, rv, res, dz, z, cnt};
        return t;
    endfunction

    initial begin
        logic       kv, r;
        logic [3:0] kc;
        int         p;

        // 2 * 3 = 6
        tv.push_back(v(1, 4'h2, 1, 0, 3'b010, 3'b000, 2'b00, 0, 0, 5'd0, 0, 0, 2'd0));
        tv.push_back(v(1, 4'hC, 1, 0, 3'b010, 3'b000, 2'b00, 0, 0, 5'd0, 0, 0, 2'd0));
        tv.push_back(v(1, 4'h3, 1, 0, 3'b010, 3'b011, 2'b00, 0, 0, 5'd0, 0, 0, 2'd0));
        tv.push_back(v(1, 4'hE, 0, 0, 3'b010, 3'b011, 2'b00, 1, 0, 5'd0, 0, 0, 2'd0));
        tv.push_back(v(0, 4'h0, 1, 0, 3'b010, 3'b011, 2'b00, 0, 1, 5'd6, 0, 0, 2'd1));
        tv.push_back(v(0, 4'h0, 1, 0, 3'b010, 3'b011, 2'b00, 0, 0, 5'd6, 0, 0, 2'd1));
        // -1 - -2 = 1, started from SHOW
        tv.push_back(v(1, 4'hB, 1, 0, 3'b010, 3'b011, 2'b00, 0, 0, 5'd6, 0, 0, 2'd1));
        tv.push_back(v(1, 4'h1, 1, 0, 3'b101, 3'b011, 2'b00, 0, 0, 5'd6, 0, 0, 2'd1));
        tv.push_back(v(1, 4'hB, 1, 0, 3'b101, 3'b011, 2'b11, 0, 0, 5'd6, 0, 0, 2'd1));
        tv.push_back(v(1, 4'hB, 1, 0, 3'b101, 3'b011, 2'b11, 0, 0, 5'd6, 0, 0, 2'd1));
        tv.push_back(v(1, 4'h2, 1, 0, 3'b101, 3'b110, 2'b11, 0, 0, 5'd6, 0, 0, 2'd1));
        tv.push_back(v(1, 4'hE, 0, 0, 3'b101, 3'b110, 2'b11, 1, 0, 5'd6, 0, 0, 2'd1));
        tv.push_back(v(0, 4'h0, 1, 0, 3'b101, 3'b110, 2'b11, 0, 1, 5'd1, 0, 0, 2'd2));
        // -0 % 0: negative zero stored as 000, divide by zero
        tv.push_back(v(1, 4'hB, 1, 0, 3'b101, 3'b110, 2'b11, 0, 0, 5'd1, 0, 0, 2'd2));
        tv.push_back(v(1, 4'h0, 1, 0, 3'b000, 3'b110, 2'b11, 0, 0, 5'd1, 0, 0, 2'd2));
        tv.push_back(v(1, 4'hD, 1, 0, 3'b000, 3'b110, 2'b01, 0, 0, 5'd1, 0, 0, 2'd2));
        tv.push_back(v(1, 4'h0, 1, 0, 3'b000, 3'b000, 2'b01, 0, 0, 5'd1, 0, 0, 2'd2));
        tv.push_back(v(1, 4'hE, 0, 0, 3'b000, 3'b000, 2'b01, 1, 0, 5'd1, 0, 0, 2'd2));
        tv.push_back(v(0, 4'h0, 1, 0, 3'b000, 3'b000, 2'b01, 0, 1, 5'd0, 1, 1, 2'd3));
        // clear from SHOW, illegal keys, clear from B_DIG
        tv.push_back(v(1, 4'hF, 1, 0, 3'b000, 3'b000, 2'b00, 0, 0, 5'd0, 0, 0, 2'd3));
        tv.push_back(v(1, 4'h7, 1, 1, 3'b000, 3'b000, 2'b00, 0, 0, 5'd0, 0, 0, 2'd3));
        tv.push_back(v(1, 4'h1, 1, 0, 3'b001, 3'b000, 2'b00, 0, 0, 5'd0, 0, 0, 2'd3));
        tv.push_back(v(1, 4'hE, 1, 1, 3'b001, 3'b000, 2'b00, 0, 0, 5'd0, 0, 0, 2'd3));
        tv.push_back(v(1, 4'hA, 1, 0, 3'b001, 3'b000, 2'b10, 0, 0, 5'd0, 0, 0, 2'd3));
        tv.push_back(v(1, 4'hB, 1, 0, 3'b001, 3'b000, 2'b10, 0, 0, 5'd0, 0, 0, 2'd3));
        tv.push_back(v(1, 4'hF, 1, 0, 3'b000, 3'b000, 2'b00, 0, 0, 5'd0, 0, 0, 2'd3));
        // 1 + 1 = 2, op_count wraps 3 -> 0
        tv.push_back(v(1, 4'h1, 1, 0, 3'b001, 3'b000, 2'b00, 0, 0, 5'd0, 0, 0, 2'd3));
        tv.push_back(v(1, 4'hA, 1, 0, 3'b001, 3'b000, 2'b10, 0, 0, 5'd0, 0, 0, 2'd3));
        tv.push_back(v(1, 4'h1, 1, 0, 3'b001, 3'b001, 2'b10, 0, 0, 5'd0, 0, 0, 2'd3));
        tv.push_back(v(1, 4'hE, 0, 0, 3'b001, 3'b001, 2'b10, 1, 0, 5'd0, 0, 0, 2'd3));
        tv.push_back(v(0, 4'h0, 1, 0, 3'b001, 3'b001, 2'b10, 0, 1, 5'd2, 0, 0, 2'd0));
        // '3' held through EXEC is consumed only after res_valid
        tv.push_back(v(1, 4'h2, 1, 0, 3'b010, 3'b001, 2'b10, 0, 0, 5'd2, 0, 0, 2'd0));
        tv.push_back(v(1, 4'hA, 1, 0, 3'b010, 3'b001, 2'b10, 0, 0, 5'd2, 0, 0, 2'd0));
        tv.push_back(v(1, 4'h1, 1, 0, 3'b010, 3'b001, 2'b10, 0, 0, 5'd2, 0, 0, 2'd0));
        tv.push_back(v(1, 4'hE, 0, 0, 3'b010, 3'b001, 2'b10, 1, 0, 5'd2, 0, 0, 2'd0));
        tv.push_back(v(1, 4'h3, 1, 0, 3'b010, 3'b001, 2'b10, 0, 1, 5'd3, 0, 0, 2'd1));
        tv.push_back(v(1, 4'h3, 1, 0, 3'b011, 3'b001, 2'b10, 0, 0, 5'd3, 0, 0, 2'd1));
        // enter EXEC again for the reset-abort sequence
        tv.push_back(v(1, 4'hC, 1, 0, 3'b011, 3'b001, 2'b00, 0, 0, 5'd3, 0, 0, 2'd1));
        tv.push_back(v(1, 4'h1, 1, 0, 3'b011, 3'b001, 2'b00, 0, 0, 5'd3, 0, 0, 2'd1));
        tv.push_back(v(1, 4'hE, 0, 0, 3'b011, 3'b001, 2'b00, 1, 0, 5'd3, 0, 0, 2'd1));

        rst       = 1'b1;
        key_valid = 1'b0;
        key_code  = 4'h0;
        cycle(0, 4'h0, 1);
        cycle(1, 4'h2, 1);
        chk("reset", act_vec(), 21'd0);

        foreach (tv[i]) begin
            cycle(tv[i].kv, tv[i].kc, 1'b0);
            chk($sformatf("vec%0d", i), act_vec(), tv[i].e);
        end

        // rst while busy: no result, everything back to zero
        cycle(0, 4'h0, 1);
        chk("rst_exec", act_vec(), 21'd0);
        cycle(0, 4'h0, 0);
        chk("after_rst", act_vec(), {1'b1, 20'd0});
        cycle(0, 4'h0, 0);
        chk("no_late_rv", act_vec(), {1'b1, 20'd0});

        for (int n = 0; n < 4000; n++) begin
            kv = ($urandom_range(0, 3) != 0);
            p  = $urandom_range(0, 9);
            if (p < 4)       kc = 4'($urandom_range(0, 3));
            else if (p < 8)  kc = 4'($urandom_range(10, 14));
            else if (p == 8) kc = 4'($urandom_range(4, 9));
            else             kc = 4'hF;
            r = ($urandom_range(0, 299) == 0);
            cycle(kv, kc, r);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
